// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline package: per-stage payload widths and packed-field offsets.
// Stages pack their fields into an opaque vector carried by pipe_stage_reg.
package cpu_pipe_pkg;

  localparam int PIPE_DEFAULT_W = 200;

  // Per-stage payload widths
  localparam int IF_ID_W  = 64;   // pc + inst
  localparam int ID_EX_W  = 168;  // pc + inst + two operands + ctrl
  localparam int EX_MEM_W = 168;  // pc + res + hi + lo + ctrl
  localparam int MEM_WB_W = 200;  // pc + res + hi + lo + rdata + ctrl

  // MEM/WB field offsets (LSB positions)
  localparam int MEM_WB_PC_LSB    = 0;
  localparam int MEM_WB_RES_LSB   = 32;
  localparam int MEM_WB_HI_LSB    = 64;
  localparam int MEM_WB_LO_LSB    = 96;
  localparam int MEM_WB_RDATA_LSB = 128;
  localparam int MEM_WB_CTRL_LSB  = 160;
  localparam int MEM_WB_CTRL_W    = 40;

  typedef struct packed {
    logic [MEM_WB_CTRL_W-1:0] ctrl;
    logic [31:0]              rdata;
    logic [31:0]              lo;
    logic [31:0]              hi;
    logic [31:0]              res;
    logic [31:0]              pc;
  } mem_wb_t;

  // Beats held = main valid + skid valid
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable; reset/clear zero it only when CLEAR_DATA=1.
// Clear takes priority over load so a flushed beat never lands.
module pipe_data_reg #(
  parameter int DATA_W     = 200,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (!resetn || clr) begin
      if (CLEAR_DATA) data_d = '0;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer (registered in_ready).
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = PIPE_DEFAULT_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              out_valid_q, out_valid_d;
  logic              in_fire, out_fire;
  logic              main_load;
  logic [DATA_W-1:0] main_src;

  assign out_fire = out_valid_q && out_ready;
  assign in_fire  = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic              skid_load;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_src     = in_data;
    if (skid_valid_q) begin
      // in_ready is low here; only a drain can move the skid beat forward
      if (out_fire) begin
        main_load    = 1'b1;
        main_src     = skid_data;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q || out_ready) begin
        main_load   = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        skid_load    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  pipe_data_reg #(.DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .load   (skid_load),
    .d      (in_data),
    .q      (skid_data)
  );

  assign occ = occ_count(out_valid_q, skid_valid_q);
`else
  // Ready path is combinational from out_ready so a stalled stage refills as it drains
  assign in_ready = !out_valid_q || out_ready;
  assign main_src = in_data;

  always_comb begin
    out_valid_d = out_valid_q;
    main_load   = 1'b0;
    if (in_fire) begin
      main_load   = 1'b1;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) out_valid_q <= 1'b0;
    else         out_valid_q <= out_valid_d;
  end

  assign occ = occ_count(out_valid_q, 1'b0);
`endif

  pipe_data_reg #(.DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .load   (main_load),
    .d      (main_src),
    .q      (out_data)
  );

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then random valid/ready.
// Expected beats are a FIFO of accepted-but-not-emitted data; its depth is the occupancy.
module tb_pipe_stage_reg;

  localparam int W = 32;
  localparam bit CLEAR = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .CLEAR_DATA(CLEAR)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           emitted = 0;
  bit           exp_zero = 1'b1;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare presented outputs against the model, pop on downstream transfer
  always @(negedge clk) begin
    if (resetn) begin
      check("occ", 64'(occ), 64'(exp_q.size()));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (CAP == 2) check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      else          check("in_ready", 64'(in_ready), 64'(exp_q.size() == 0 || out_ready));
      if (out_valid && exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q[0]));
      if (!out_valid && exp_zero && CLEAR) check("cleared_data", 64'(out_data), 64'd0);
      if (prev_stall) check("stall_stable", 64'(out_data), 64'(prev_data));
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      if (out_valid && out_ready && exp_q.size() != 0) begin
        $display("OUT data=%08h occ=%0d", out_data, occ);
        void'(exp_q.pop_front());
        emitted++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Capture: record accepted beats (after the monitor has popped this cycle's output)
  always @(negedge clk) begin
    #1;
    if (!resetn || flush) begin
      exp_q.delete();
      exp_zero = 1'b1;
    end else if (in_valid && in_ready) begin
      exp_q.push_back(in_data);
      exp_zero = 1'b0;
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r,
                       input bit f = 1'b0, input bit rn = 1'b1);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    resetn    = rn;
  endtask

  int base;

  initial begin
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0);

    // Stream 1..8 with downstream always ready: no bubbles
    base = emitted;
    for (int i = 1; i <= 8; i++) drive(1, W'(i), 1);
    drive(0, '0, 1);
    drive(0, '0, 1);
    check("stream_count", 64'(emitted - base), 64'd8);

    // Stall after 0xA5, then release
    base = emitted;
    drive(1, 32'hA5, 0);
    drive(1, 32'h5A, 0);
    drive(1, 32'h5A, 0);
    drive(1, 32'h5A, 0);
    @(negedge clk);
    check("stall_occ", 64'(occ), 64'(CAP));
    drive(CAP == 1, 32'h5A, 1);
    drive(0, '0, 1);
    drive(0, '0, 1);
    drive(0, '0, 1);
    check("stall_count", 64'(emitted - base), 64'd2);

    // Flush with a same-cycle beat that must be discarded
    base = emitted;
    drive(1, 32'h11, 0);
    drive(1, 32'h22, 0);
    drive(1, 32'h77, 0, 1);
    drive(0, '0, 1);
    @(negedge clk);
    check("flush_occ", 64'(occ), 64'd0);
    drive(0, '0, 1);
    check("flush_count", 64'(emitted - base), 64'd0);

    // Reset for one cycle mid-stall
    drive(1, 32'h33, 0);
    drive(1, 32'h44, 0);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_data", 64'(out_data), 64'd0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
            ($urandom % 64) == 0, ($urandom % 200) != 0);
    end
    drive(0, '0, 1);
    for (int i = 0; i < 4; i++) drive(0, '0, 1);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
